pipeline_issuer: RTL and testbench

- Front-end dispatcher that drives the four-stage register/ALU/memory pipeline's instruction inputs (ra1, ra2, rwa, ma, func).
- Holds a small program buffer loaded over a write port and issues one instruction per cycle on start.
- Detects read-after-write hazards against in-flight destinations and inserts bubbles, since the pipeline has no forwarding.
- Signals done once the last instruction has retired through stage 4.

---
 rtl/pipeline_issuer.sv | 167 ++++++++++++++++
 tb/tb_pipeline_issuer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_issuer.sv
// Program-buffer issuer for the four-stage register/ALU/memory pipeline.
// Inserts bubbles on read-after-write hazards because the pipeline has no forwarding.
//   state | meaning
//   IDLE  | buffer writable, waiting for start
//   RUN   | fetching buffer[pc], issuing or stalling each cycle
//   DRAIN | last instruction issued, waiting for it to retire
//   DONE  | one-cycle completion pulse
module pipeline_issuer #(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int HAZ_DEPTH = 2,
    parameter int PIPE_LAT  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [23:0]   load_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    output logic          issue_valid,
    output logic [3:0]    func,
    output logic [3:0]    rwa,
    output logic [3:0]    ra1,
    output logic [3:0]    ra2,
    output logic [7:0]    ma,
    output logic          busy,
    output logic          done,
    output logic [7:0]    stall_cnt
);
    localparam int CW = $clog2(PIPE_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                      state_q, state_d;
    logic [23:0]                 buf_mem [DEPTH];
    logic [AW:0]                 pc_q, pc_d, len_q, len_d;
    logic [CW-1:0]               drain_q, drain_d;
    logic [7:0]                  stall_q, stall_d;
    logic [HAZ_DEPTH-1:0]        slot_v_q, slot_v_d;
    logic [HAZ_DEPTH-1:0][3:0]   slot_rwa_q, slot_rwa_d;
    logic                        valid_q, valid_d, busy_q, busy_d, done_q, done_d;
    logic [23:0]                 instr_q, instr_d;
    logic [23:0]                 cand;
    logic                        hazard;

    // The buffer is deliberately left out of reset so a restart can replay it.
    always_ff @(posedge clk) begin
        if (rst_n && load_en && state_q == S_IDLE) begin
            buf_mem[load_addr] <= load_data;
        end
    end

    assign cand = buf_mem[pc_q[AW-1:0]];

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (slot_v_q[i] && (slot_rwa_q[i] == cand[15:12] || slot_rwa_q[i] == cand[11:8])) begin
                hazard = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        len_d      = len_q;
        drain_d    = drain_q;
        stall_d    = stall_q;
        slot_v_d   = slot_v_q;
        slot_rwa_d = slot_rwa_q;
        valid_d    = 1'b0;
        instr_d    = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d    = prog_len;
                    pc_d     = '0;
                    stall_d  = '0;
                    slot_v_d = '0;
                    state_d  = (prog_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 1; i < HAZ_DEPTH; i++) begin
                    slot_v_d[i]   = slot_v_q[i-1];
                    slot_rwa_d[i] = slot_rwa_q[i-1];
                end
                if (!hazard) begin
                    valid_d       = 1'b1;
                    instr_d       = cand;
                    slot_v_d[0]   = 1'b1;
                    slot_rwa_d[0] = cand[19:16];
                    pc_d          = pc_q + 1'b1;
                    if (pc_q == len_q - 1'b1) begin
                        state_d = S_DRAIN;
                        drain_d = CW'(PIPE_LAT);
                    end
                end else begin
                    slot_v_d[0]   = 1'b0;
                    slot_rwa_d[0] = '0;
                    if (stall_q != 8'hFF) begin
                        stall_d = stall_q + 8'd1;
                    end
                end
            end
            S_DRAIN: begin
                for (int i = 1; i < HAZ_DEPTH; i++) begin
                    slot_v_d[i]   = slot_v_q[i-1];
                    slot_rwa_d[i] = slot_rwa_q[i-1];
                end
                slot_v_d[0]   = 1'b0;
                slot_rwa_d[0] = '0;
                if (drain_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            len_q      <= '0;
            drain_q    <= '0;
            stall_q    <= '0;
            slot_v_q   <= '0;
            slot_rwa_q <= '0;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            len_q      <= len_d;
            drain_q    <= drain_d;
            stall_q    <= stall_d;
            slot_v_q   <= slot_v_d;
            slot_rwa_q <= slot_rwa_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign issue_valid = valid_q;
    assign func        = instr_q[23:20];
    assign rwa         = instr_q[19:16];
    assign ra1         = instr_q[15:12];
    assign ra2         = instr_q[11:8];
    assign ma          = instr_q[7:0];
    assign busy        = busy_q;
    assign done        = done_q;
    assign stall_cnt   = stall_q;
endmodule

// File: tb/tb_pipeline_issuer.sv
// Scoreboard bench for pipeline_issuer: directed programs push expected issues and
// done events; a negedge monitor pops and compares them as the DUT presents them.
module tb_pipeline_issuer;
    localparam int PIPE_LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_en = 1'b0;
    logic [3:0]  load_addr = '0;
    logic [23:0] load_data = '0;
    logic [4:0]  prog_len = '0;
    logic        start = 1'b0;
    logic        issue_valid, busy, done;
    logic [3:0]  func, rwa, ra1, ra2;
    logic [7:0]  ma, stall_cnt;

    pipeline_issuer dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .prog_len(prog_len), .start(start),
        .issue_valid(issue_valid), .func(func), .rwa(rwa), .ra1(ra1), .ra2(ra2),
        .ma(ma), .busy(busy), .done(done), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {logic [23:0] w; int c;} iss_t;
    typedef struct {int st; int c;} dn_t;

    iss_t        exp_q[$];
    dn_t         done_q[$];
    logic [23:0] tb_mem [16];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [23:0] mk(input int f, input int w, input int a1, input int a2, input int m);
        return {f[3:0], w[3:0], a1[3:0], a2[3:0], m[7:0]};
    endfunction

    // Monitor: every presented instruction or done pulse must match the head of its queue.
    always @(negedge clk) begin
        if (issue_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", {func, rwa, ra1, ra2, ma}, 0);
                chk("unexpected_issue_valid", 1, 0);
            end else begin
                iss_t e;
                e = exp_q.pop_front();
                chk("issue_word", {func, rwa, ra1, ra2, ma}, e.w);
                chk("issue_cycle", cyc, e.c);
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                dn_t d;
                d = done_q.pop_front();
                chk("done_cycle", cyc, d.c);
                chk("done_stall_cnt", stall_cnt, d.st);
                chk("done_busy_low", busy, 0);
            end
        end
    end

    task automatic load(input int a, input logic [23:0] d);
        @(negedge clk);
        load_en = 1'b1; load_addr = a[3:0]; load_data = d;
        tb_mem[a] = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Offsets are hand-computed bubble-adjusted issue slots relative to the first issue.
    task automatic start_run(input int len, input int o0, input int o1, input int o2, input int stall,
                             input bit ld, input int la, input logic [23:0] ldd);
        int   offs[3];
        int   s;
        iss_t e;
        dn_t  d;
        offs = '{o0, o1, o2};
        @(negedge clk);
        start = 1'b1; prog_len = len[4:0];
        if (ld) begin
            load_en = 1'b1; load_addr = la[3:0]; load_data = ldd;
            tb_mem[la] = ldd;
        end
        s = cyc + 1;
        for (int j = 0; j < len; j++) begin
            e.w = tb_mem[j];
            e.c = s + 1 + offs[j];
            exp_q.push_back(e);
        end
        d.st = stall;
        d.c  = (len == 0) ? s : s + 1 + offs[len-1] + PIPE_LAT + 1;
        done_q.push_back(d);
        @(negedge clk);
        start = 1'b0; load_en = 1'b0;
    endtask

    task automatic wait_done(input int stall);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) chk("done_timeout", 0, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("issue_queue_drained", exp_q.size(), 0);
        chk("done_queue_drained", done_q.size(), 0);
        chk("stall_cnt_hold", stall_cnt, stall);
        chk("idle_busy_low", busy, 0);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_issue_valid"}, issue_valid, 0);
        chk({nm, "_fields"}, {func, rwa, ra1, ra2, ma}, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_stall_cnt"}, stall_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with start held high: start must be ignored.
        start = 1'b1; prog_len = 5'd3;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("post_reset_busy", busy, 0);
        chk("post_reset_valid", issue_valid, 0);

        // Three independent instructions, back-to-back issue.
        load(0, mk(0, 1, 4, 5, 8'h10));
        load(1, mk(0, 2, 6, 7, 8'h11));
        load(2, mk(0, 3, 8, 9, 8'h12));
        start_run(3, 0, 1, 2, 0, 1'b0, 0, '0);
        chk("run_busy_high", busy, 1);
        wait_done(0);

        // Read of r5 right after its write: two bubbles.
        load(0, mk(1, 5, 1, 2, 20));
        load(1, mk(2, 6, 5, 3, 21));
        start_run(2, 0, 3, 0, 2, 1'b0, 0, '0);
        wait_done(2);

        // r5 read two slots after its write: one bubble; instr0 loaded with start.
        load(1, mk(2, 6, 3, 4, 31));
        load(2, mk(3, 7, 8, 5, 32));
        start_run(3, 0, 1, 3, 1, 1'b1, 0, mk(1, 5, 1, 2, 30));
        wait_done(1);

        // Empty program.
        start_run(0, 0, 0, 0, 0, 1'b0, 0, '0);
        wait_done(0);

        // start and load_en during RUN are ignored; a rerun sees the same buffer.
        start_run(3, 0, 1, 3, 1, 1'b0, 0, '0);
        load_en = 1'b1; load_addr = 4'd0; load_data = 24'hFFFFFF;
        start = 1'b1; prog_len = 5'd5;
        @(negedge clk);
        load_addr = 4'd2;
        @(negedge clk);
        load_en = 1'b0; start = 1'b0;
        wait_done(1);
        start_run(3, 0, 1, 3, 1, 1'b0, 0, '0);
        wait_done(1);

        // Reset mid-RUN abandons the run; restart replays from pc=0.
        start_run(3, 0, 1, 3, 1, 1'b0, 0, '0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        done_q.delete();
        check_zero("mid_run_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_done_after_abort", done_q.size(), 0);
        start_run(3, 0, 1, 3, 1, 1'b0, 0, '0);
        wait_done(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
